bcd_display_scanner: RTL and testbench

- Downstream consumer of the BCD up/down counter digits.
- Takes a packed 4-digit BCD value from the counter chain and drives a time-multiplexed, common-anode 7-segment display: one digit per slot, four slots per frame.
- Updates are frame-coherent: a new value never changes the display partway through a frame.
- Provides leading-zero blanking, anti-ghost blanking at the start of each slot, and a dash for non-BCD codes.

---
 rtl/bcd_display_scanner.sv | 96 +++++++++
 tb/tb_bcd_display_scanner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: frame-coherent 4-digit multiplexed common-anode 7-segment driver for packed BCD.
// Ports: clk, clr (async, active-high), load/bcd_in (capture into pending), lzb (leading-zero blanking),
//        seg (active-low gfedcba), an (active-low anodes), digit_sel (slot index), frame_done (1-cycle pulse).
//        Macro BCD_DISP_OVF_BLINK_EN adds input ovf, which blanks alternate frames for eight frames.
module bcd_display_scanner #(
  parameter int PRESCALE = 1024,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        lzb,
`ifdef BCD_DISP_OVF_BLINK_EN
  input  logic        ovf,
`endif
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BL   = PW'(BLANK);
  logic [PW-1:0] psc_q, psc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d, disp_q, disp_d;
  logic          pv_q, pv_d;
  logic          wrap, bnd, lz_blank, hide;
  logic [3:0]    nib, an_d;
  logic [6:0]    seg_d;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction
`ifdef BCD_DISP_OVF_BLINK_EN
  logic [3:0] blk_q, blk_d;
  // Odd counts blank the whole frame; ovf (re)starts an eight-frame blink sequence.
  always_comb begin
    blk_d = ovf ? 4'd8 : (bnd && blk_q != 4'd0) ? blk_q - 4'd1 : blk_q;
    hide  = blk_q[0];
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) blk_q <= 4'd0;
    else     blk_q <= blk_d;
`else
  assign hide = 1'b0;
`endif
  always_comb begin
    wrap     = psc_q == LAST;
    bnd      = wrap && idx_q == 2'd3;
    psc_d    = wrap ? '0 : psc_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    disp_d   = (bnd && pv_q) ? pend_q : disp_q;
    pend_d   = load ? bcd_in : pend_q;
    pv_d     = load | (pv_q & ~bnd);
    nib      = disp_q[{idx_q, 2'b00} +: 4];
    // Digit i blanks when it and all higher digits are zero; digit 0 always shows.
    lz_blank = lzb && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'h0;
    an_d     = (psc_q < BL || lz_blank || hide) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d    = dec(nib);
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      psc_q      <= '0;
      idx_q      <= 2'd0;
      pend_q     <= 16'h0;
      disp_q     <= 16'h0;
      pv_q       <= 1'b0;
      seg        <= 7'h7F;
      an         <= 4'hF;
      digit_sel  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      pv_q       <= pv_d;
      seg        <= seg_d;
      an         <= an_d;
      digit_sel  <= idx_q;
      frame_done <= bnd;
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed plus random stimulus checked against a frame-level reference model.
module tb_bcd_display_scanner;
  localparam int P = 4;
  localparam int B = 1;
  localparam int F = 4 * P;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic        lzb = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;
`ifdef BCD_DISP_OVF_BLINK_EN
  logic        ovf = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  int c = 0;
  logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
  logic        m_pv = 1'b0;
  int          m_blk = 0;
  bcd_display_scanner #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .clr(clr), .load(load), .bcd_in(bcd_in), .lzb(lzb),
`ifdef BCD_DISP_OVF_BLINK_EN
    .ovf(ovf),
`endif
    .seg(seg), .an(an), .digit_sel(digit_sel), .frame_done(frame_done));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000; 4'd1: return 7'b1111001; 4'd2: return 7'b0100100;
      4'd3: return 7'b0110000; 4'd4: return 7'b0011001; 4'd5: return 7'b0010010;
      4'd6: return 7'b0000010; 4'd7: return 7'b1111000; 4'd8: return 7'b0000000;
      4'd9: return 7'b0010000; default: return 7'b0111111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, c);
    end
  endtask
  task automatic model_reset();
    c = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0; m_blk = 0;
  endtask
  // One clock: predict from the state seen before the edge, advance the model, check on the falling edge.
  task automatic step();
    int p, i;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_fd, bl, bnd;
    p     = c % P;
    i     = (c / P) % 4;
    e_seg = seg_of(m_disp[4*i +: 4]);
    bl    = lzb && i > 0 && (m_disp >> (4*i)) == 16'h0;
    e_an  = (p < B || bl || (m_blk % 2 == 1)) ? 4'hF : 4'hF & ~(4'b0001 << i);
    bnd   = (c % F) == F - 1;
    e_fd  = bnd;
    @(posedge clk);
    if (bnd && m_pv) begin m_disp = m_pend; m_pv = 1'b0; end
    if (load) begin m_pend = bcd_in; m_pv = 1'b1; end
`ifdef BCD_DISP_OVF_BLINK_EN
    if (ovf) m_blk = 8;
    else if (bnd && m_blk != 0) m_blk--;
`endif
    c++;
    @(negedge clk);
    chk("seg", 16'(seg), 16'(e_seg));
    chk("an", 16'(an), 16'(e_an));
    chk("digit_sel", 16'(digit_sel), 16'(i));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic do_load(input logic [15:0] v);
    load = 1'b1; bcd_in = v; step(); load = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_fd", 16'(frame_done), 16'h0);
    clr = 1'b0;
    model_reset();
    step();
    chk("first_blank", 16'(an), 16'hF);
    step();
    chk("first_anode", 16'(an), 16'hE);
    do_load(16'h1234);
    run(2 * F);
    while (c % F != 0) step();
    step(); step();
    chk("slot0_an", 16'(an), 16'hE);
    chk("slot0_seg", 16'(seg), 16'(7'b0011001));
    lzb = 1'b1;
    do_load(16'h0070);
    run(2 * F + 3);
    do_load(16'h0000);
    run(2 * F);
    lzb = 1'b0;
    do_load(16'h1234);
    run(F);
    while (c % F != P + 1) step();
    do_load(16'h5555);
    run(2 * F);
    lzb = 1'b1;
    do_load(16'h00AF);
    run(2 * F);
    while (c % F != F - 1) step();
    do_load(16'h0903);
    run(3 * F);
    do_load(16'h9999);
    run(3);
    #2 clr = 1'b1;
    #1;
    chk("mid_rst_seg", 16'(seg), 16'h7F);
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_fd", 16'(frame_done), 16'h0);
    chk("mid_rst_sel", 16'(digit_sel), 16'h0);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    run(3 * F);
    for (int k = 0; k < 3000; k++) begin
      load   = ($urandom % 6) == 0;
      bcd_in = ($urandom % 3 == 0) ? 16'($urandom) : {12'($urandom % 4) == 0 ? 12'h0 : 12'($urandom), 4'($urandom % 10)};
      if ($urandom % 40 == 0) lzb = ~lzb;
      step();
    end
    load = 1'b0;
`ifdef BCD_DISP_OVF_BLINK_EN
    lzb = 1'b0;
    do_load(16'h4321);
    run(2 * F);
    while (c % F != 5) step();
    ovf = 1'b1; step(); ovf = 1'b0;
    run(10 * F);
    ovf = 1'b1; step(); ovf = 1'b0;
    run(3 * F);
    ovf = 1'b1; step(); ovf = 1'b0;
    run(10 * F);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
